// File: rtl/fbpal_burst.sv
// rtl/fbpal_burst.sv - burst palette loader: DDR bursts into a beat FIFO, two palette writes per beat
module fbpal_burst #(
    parameter int PAL_AW      = 8,
    parameter int BURST       = 16,
    parameter int BASE_OFFSET = 4096,
    parameter int FIFO_AW     = 5
) (
    input  logic              ram_clk,
    input  logic              reset_n,
    input  logic              en_in,
    output logic              en_out,
    output logic              busy,
    output logic [28:0]       ram_address,
    output logic [7:0]        ram_burstcount,
    input  logic              ram_waitrequest,
    input  logic [63:0]       ram_readdata,
    input  logic              ram_readdatavalid,
    output logic              ram_read,
    input  logic [31:0]       fb_address,
    input  logic              pal_en,
    output logic [PAL_AW-1:0] pal_a,
    output logic [23:0]       pal_d,
    output logic              pal_wr
);

    localparam int NBEATS = 2 ** (PAL_AW - 1);
    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam int RXW    = $clog2(BURST) + 1;
    localparam int CW     = FIFO_AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RECV,
        S_DRAIN,
        S_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       base_addr_q;
    logic [PAL_AW-1:0] beat_idx_q, beat_idx_d;
    logic [RXW-1:0]    rx_cnt_q, rx_cnt_d;
    logic              req_q, req_d;
    logic              en_out_q, en_out_d;
    logic              busy_q, busy_d;
    logic              rd_q, rd_d;
    logic [28:0]       addr_q, addr_d;
    logic [7:0]        bc_q, bc_d;

    // Beat FIFO keeps only the two 24-bit colour fields of each beat.
    logic [47:0]        fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0]      cnt_q;

    logic              phase_q;
    logic [23:0]       hold_q;
    logic [PAL_AW-1:0] wr_addr_q;
    logic [PAL_AW-1:0] pal_a_q;
    logic [23:0]       pal_d_q;
    logic              pal_wr_q;

    logic              accept;
    logic              count_rx;
    logic              rx_last;
    logic              load_start;
    logic [PAL_AW-1:0] next_idx;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_room;
    logic              fifo_push;
    logic              fifo_pop;
    logic [47:0]       fifo_head;
    logic              unused_bits;

    assign unused_bits = ^{ram_readdata[63:56], ram_readdata[31:24], base_addr_q[2:0]};

    assign accept     = rd_q & ~ram_waitrequest;
    assign next_idx   = beat_idx_q + PAL_AW'(BURST);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(DEPTH));
    assign fifo_room  = (cnt_q <= CW'(DEPTH - BURST));
    assign fifo_head  = fifo_mem[rptr_q];
    assign fifo_pop   = pal_en & ~phase_q & ~fifo_empty;

    // Next-state, command and beat accounting for the load sequencer.
    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        req_d      = req_q;
        en_out_d   = en_out_q;
        busy_d     = busy_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        bc_d       = bc_q;
        load_start = 1'b0;
        count_rx   = 1'b0;

        case (state_q)
            S_ISSUE:         count_rx = accept & ram_readdatavalid;
            S_RECV, S_FLUSH: count_rx = ram_readdatavalid;
            default:         count_rx = 1'b0;
        endcase
        rx_last  = count_rx && (rx_cnt_q == RXW'(BURST - 1));
        rx_cnt_d = rx_last ? '0 : rx_cnt_q + RXW'(count_rx);

        case (state_q)
            S_IDLE: begin
                if (!pal_en) begin
                    en_out_d = en_in;
                end else if (en_out_q != en_in) begin
                    req_d      = en_in;
                    beat_idx_d = '0;
                    busy_d     = 1'b1;
                    load_start = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rd_q) begin
                    // An offered command must be accepted even when aborting.
                    if (accept) begin
                        rd_d    = 1'b0;
                        state_d = pal_en ? S_RECV : S_FLUSH;
                    end
                end else if (!pal_en) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (fifo_room) begin
                    rd_d   = 1'b1;
                    addr_d = base_addr_q[31:3] + 29'(beat_idx_q);
                    bc_d   = 8'(BURST);
                end
            end
            S_RECV: begin
                if (!pal_en) state_d = S_FLUSH;
            end
            S_DRAIN: begin
                if (!pal_en) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (fifo_empty && !phase_q) begin
                    en_out_d = req_q;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: ;
        endcase

        // The final beat of a burst decides between next burst, drain or abort.
        if (rx_last) begin
            if (state_q == S_FLUSH || !pal_en) begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end else begin
                beat_idx_d = (next_idx == PAL_AW'(NBEATS)) ? '0 : next_idx;
                state_d    = (next_idx == PAL_AW'(NBEATS)) ? S_DRAIN : S_ISSUE;
            end
        end
    end

    assign fifo_push = count_rx & pal_en & (state_q != S_FLUSH);

    // Sequencer registers and the registered framebuffer base.
    always_ff @(posedge ram_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            base_addr_q <= '0;
            beat_idx_q  <= '0;
            rx_cnt_q    <= '0;
            req_q       <= 1'b0;
            en_out_q    <= 1'b0;
            busy_q      <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            bc_q        <= '0;
        end else begin
            state_q     <= state_d;
            base_addr_q <= fb_address - 32'(BASE_OFFSET);
            beat_idx_q  <= beat_idx_d;
            rx_cnt_q    <= rx_cnt_d;
            req_q       <= req_d;
            en_out_q    <= en_out_d;
            busy_q      <= busy_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            bc_q        <= bc_d;
        end
    end

    // FIFO storage, no reset needed since occupancy is tracked separately.
    always_ff @(posedge ram_clk) begin
        if (fifo_push) fifo_mem[wptr_q] <= {ram_readdata[55:32], ram_readdata[23:0]};
    end

    // FIFO pointers; dropping pal_en empties it at once.
    always_ff @(posedge ram_clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (!pal_en) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (fifo_push) wptr_q <= wptr_q + 1'b1;
            if (fifo_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    // Write side: even entry on the pop cycle, odd entry from the held half next cycle.
    always_ff @(posedge ram_clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= 1'b0;
            hold_q    <= '0;
            wr_addr_q <= '0;
            pal_a_q   <= '0;
            pal_d_q   <= '0;
            pal_wr_q  <= 1'b0;
        end else if (!pal_en) begin
            phase_q   <= 1'b0;
            wr_addr_q <= '0;
            pal_wr_q  <= 1'b0;
        end else if (load_start) begin
            phase_q   <= 1'b0;
            wr_addr_q <= '0;
            pal_wr_q  <= 1'b0;
        end else if (phase_q) begin
            pal_wr_q  <= 1'b1;
            pal_d_q   <= hold_q;
            pal_a_q   <= wr_addr_q;
            wr_addr_q <= wr_addr_q + 1'b1;
            phase_q   <= 1'b0;
        end else if (fifo_pop) begin
            pal_wr_q  <= 1'b1;
            pal_d_q   <= fifo_head[23:0];
            hold_q    <= fifo_head[47:24];
            pal_a_q   <= wr_addr_q;
            wr_addr_q <= wr_addr_q + 1'b1;
            phase_q   <= 1'b1;
        end else begin
            pal_wr_q  <= 1'b0;
        end
    end

    // Issue gating must make a push into a full FIFO impossible.
    always @(posedge ram_clk) begin
        if (reset_n) assert (!(fifo_push && fifo_full && !fifo_pop));
    end

    assign en_out         = en_out_q;
    assign busy           = busy_q;
    assign ram_read       = rd_q;
    assign ram_address    = addr_q;
    assign ram_burstcount = bc_q;
    assign pal_a          = pal_a_q;
    assign pal_d          = pal_d_q;
    assign pal_wr         = pal_wr_q;

endmodule

// File: tb/tb_fbpal_burst.sv
// tb/tb_fbpal_burst.sv - randomized self-checking bench for fbpal_burst
module tb_fbpal_burst;

    logic        ram_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en_in = 1'b0;
    logic        en_out;
    logic        busy;
    logic [28:0] ram_address;
    logic [7:0]  ram_burstcount;
    logic        ram_waitrequest = 1'b0;
    logic [63:0] ram_readdata = '0;
    logic        ram_readdatavalid = 1'b0;
    logic        ram_read;
    logic [31:0] fb_address = '0;
    logic        pal_en = 1'b0;
    logic [7:0]  pal_a;
    logic [23:0] pal_d;
    logic        pal_wr;

    fbpal_burst dut (
        .ram_clk           (ram_clk),
        .reset_n           (reset_n),
        .en_in             (en_in),
        .en_out            (en_out),
        .busy              (busy),
        .ram_address       (ram_address),
        .ram_burstcount    (ram_burstcount),
        .ram_waitrequest   (ram_waitrequest),
        .ram_readdata      (ram_readdata),
        .ram_readdatavalid (ram_readdatavalid),
        .ram_read          (ram_read),
        .fb_address        (fb_address),
        .pal_en            (pal_en),
        .pal_a             (pal_a),
        .pal_d             (pal_d),
        .pal_wr            (pal_wr)
    );

    always #5 ram_clk = ~ram_clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference contents of DDR: every word address maps to a known beat.
    logic [23:0] salt = '0;

    function automatic logic [63:0] beat_of(input logic [28:0] w);
        logic [23:0] k;
        k = w[23:0];
        return {8'hFF, (24'hA0000 + k) ^ salt, 8'hEE, (24'h50000 + k) ^ salt};
    endfunction

    // Scoreboard state for the load in progress.
    int          exp_idx = 0;
    int          cmd_count = 0;
    logic [28:0] exp_base = '0;
    logic        exp_req = 1'b0;

    // RAM model: wait-states per command, beats returned from the cycle after acceptance.
    logic [28:0] pending[$];
    int          wait_mode = 0;
    int          gap_mode = 0;
    int          delivered = 0;

    initial begin
        bit          in_cmd;
        bit          prev_hold;
        int          wait_left;
        logic [28:0] prev_addr;
        logic [7:0]  prev_bc;
        in_cmd    = 0;
        prev_hold = 0;
        wait_left = 0;
        prev_addr = '0;
        prev_bc   = '0;
        forever begin
            @(negedge ram_clk);
            #1;
            if (!reset_n) begin
                pending.delete();
                ram_readdatavalid = 1'b0;
                ram_waitrequest   = 1'b0;
                in_cmd    = 0;
                prev_hold = 0;
            end else begin
                if (pending.size() > 0 && (gap_mode == 0 || $urandom_range(3) != 0)) begin
                    ram_readdatavalid = 1'b1;
                    ram_readdata      = beat_of(pending.pop_front());
                    delivered++;
                end else begin
                    ram_readdatavalid = 1'b0;
                    ram_readdata      = {$urandom, $urandom};
                end
                if (prev_hold) begin
                    check_eq("cmd_read_held", ram_read, 1'b1);
                    check_eq("cmd_addr_stable", ram_address, prev_addr);
                    check_eq("cmd_bc_stable", ram_burstcount, prev_bc);
                end
                if (ram_read) begin
                    if (!in_cmd) begin
                        in_cmd = 1;
                        wait_left = (wait_mode == 1) ? 5 : (wait_mode == 2) ? $urandom_range(3) : 0;
                    end
                    if (wait_left > 0) begin
                        ram_waitrequest = 1'b1;
                        wait_left--;
                        prev_hold = 1;
                        prev_addr = ram_address;
                        prev_bc   = ram_burstcount;
                    end else begin
                        ram_waitrequest = 1'b0;
                        in_cmd    = 0;
                        prev_hold = 0;
                        check_eq("cmd_addr", ram_address, exp_base + 29'(16 * cmd_count));
                        check_eq("cmd_bc", ram_burstcount, 8'd16);
                        for (int i = 0; i < 16; i++) pending.push_back(ram_address + 29'(i));
                        cmd_count++;
                    end
                end else begin
                    ram_waitrequest = 1'b0;
                    in_cmd    = 0;
                    prev_hold = 0;
                end
            end
        end
    end

    // Palette write monitor: each write must match the spec-derived entry for its index.
    initial begin
        logic        prev_busy;
        logic [28:0] w;
        logic [63:0] b;
        logic [23:0] ed;
        prev_busy = 1'b0;
        forever begin
            @(negedge ram_clk);
            #3;
            if (busy && !prev_busy) begin
                exp_idx   = 0;
                cmd_count = 0;
                exp_base  = 29'((fb_address - 32'd4096) >> 3);
                exp_req   = en_in;
            end
            prev_busy = busy;
            if (pal_wr) begin
                w  = exp_base + 29'(exp_idx / 2);
                b  = beat_of(w);
                ed = exp_idx[0] ? b[55:32] : b[23:0];
                check_eq("pal_a", pal_a, exp_idx[7:0]);
                check_eq("pal_d", pal_d, ed);
                if (exp_idx == 255) check_eq("en_out_before_done", en_out, !exp_req);
                exp_idx++;
            end
        end
    end

    task automatic tick();
        @(negedge ram_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctrl"}, {en_out, busy, ram_read, pal_wr}, 4'b0);
        check_eq({tag, "_addr"}, ram_address, 29'd0);
        check_eq({tag, "_bc"}, ram_burstcount, 8'd0);
        check_eq({tag, "_pal"}, {pal_a, pal_d}, 32'd0);
    endtask

    task automatic wait_load(input logic req, input string tag);
        int n;
        n = 0;
        while (!busy && n < 50) begin tick(); n++; end
        check_eq({tag, "_start"}, busy, 1'b1);
        n = 0;
        while (busy && n < 6000) begin tick(); n++; end
        check_eq({tag, "_done"}, busy, 1'b0);
        check_eq({tag, "_nwr"}, exp_idx, 256);
        check_eq({tag, "_ncmd"}, cmd_count, 8);
        check_eq({tag, "_en_out"}, en_out, req);
    endtask

    task automatic quiet_window(input string tag, input int cycles);
        int nrd;
        int nbusy;
        nrd = 0;
        nbusy = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (ram_read) nrd++;
            if (busy) nbusy++;
        end
        check_eq({tag, "_no_read"}, nrd, 0);
        check_eq({tag, "_no_busy"}, nbusy, 0);
    endtask

    initial begin
        logic req1;
        int   n;
        int   nwr;
        int   nrd;

        // Reset state.
        reset_n = 1'b0;
        tick();
        check_all_zero("reset");
        repeat (2) tick();
        reset_n = 1'b1;
        pal_en  = 1'b1;
        fb_address = 32'h0010_2000;
        repeat (4) tick();
        check_eq("idle_matched", {busy, ram_read, en_out}, 3'b0);

        // Zero-wait, continuous data.
        en_in = 1'b1;
        wait_load(1'b1, "basic");

        // Base 0 with five wait-states per command and the k-indexed beat pattern.
        fb_address = 32'h0000_1000;
        wait_mode  = 1;
        repeat (3) tick();
        en_in = ~en_in;
        wait_load(en_in, "wait5");

        // Randomized base, salt, wait-states and data gaps.
        wait_mode = 2;
        gap_mode  = 1;
        for (int r = 0; r < 3; r++) begin
            fb_address = $urandom;
            salt       = 24'($urandom);
            repeat (3) tick();
            en_in = ~en_in;
            wait_load(en_in, "rand");
        end

        // Abort after beat 5 of burst 3.
        delivered = 0;
        en_in = ~en_in;
        n = 0;
        while (delivered < 53 && n < 3000) begin tick(); n++; end
        check_eq("abort_reached", delivered >= 53, 1'b1);
        pal_en = 1'b0;
        tick();
        nwr = 0;
        nrd = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (pal_wr) nwr++;
            if (ram_read) nrd++;
        end
        check_eq("abort_no_wr", nwr, 0);
        check_eq("abort_no_cmd", nrd, 0);
        check_eq("abort_absorbed", pending.size(), 0);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_en_out", en_out, en_in);
        pal_en = 1'b1;
        quiet_window("abort_after", 30);

        // Two toggles mid-load: one load, then stays idle.
        en_in = ~en_in;
        req1  = en_in;
        repeat (60) tick();
        en_in = ~en_in;
        repeat (40) tick();
        en_in = ~en_in;
        wait_load(req1, "tog2");
        quiet_window("tog2_after", 30);

        // One toggle mid-load: a second full load follows.
        en_in = ~en_in;
        req1  = en_in;
        repeat (80) tick();
        en_in = ~en_in;
        wait_load(req1, "tog1a");
        wait_load(en_in, "tog1b");

        // Asynchronous reset mid-burst, then recovery.
        en_in = ~en_in;
        n = 0;
        while (cmd_count < 3 && n < 3000) begin tick(); n++; end
        check_eq("rst_reached", cmd_count >= 3, 1'b1);
        repeat (2) tick();
        reset_n = 1'b0;
        en_in   = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (3) tick();
        reset_n = 1'b1;
        quiet_window("post_rst", 30);
        en_in = 1'b1;
        wait_load(1'b1, "recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
